clock_ctrl: RTL and testbench
=============================

CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 Parameter: TICK_DIV, 100_000_000, clk cycles per 1-s tick (>=4).
REQ-002 Port: clk  in  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: btn_mode  in  1  mode button.
  - Asynchronous; held for an arbitrary number of cycles.
REQ-005 Port: btn_set  in  1  set/increment button.
  - Asynchronous; held for an arbitrary number of cycles.
REQ-006 Port: sec_carry  in  1  level, high while seconds counter = 59.
REQ-007 Port: min_carry  in  1  level, high while minutes counter = 59.
REQ-008 Port: sec_en  out  1  seconds counter count enable, 1-cycle pulse.
REQ-009 Port: min_en  out  1  minutes counter count enable, 1-cycle pulse.
REQ-010 Port: hour_en  out  1  hours (cnt24) count enable, 1-cycle pulse.
REQ-011 Port: min_inc  out  1  minutes manual increment, 1-cycle pulse.
REQ-012 Port: hour_inc  out  1  hours manual increment (cnt24 cnt_inc), 1-cycle pulse.
REQ-013 Port: sec_clr  out  1  seconds counter synchronous clear, 1-cycle pulse.
REQ-014 Port: mode  out  2  current mode_t state.
REQ-015 Port: blink  out  1  display blink gate for the field being set.

Function
REQ-016 All outputs SHALL be driven directly from flops.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick = (count == TICK_DIV-1).
REQ-018 Each button SHALL pass a 2-flop synchronizer plus rising-edge detect.
  - Registered output pulse asserts on the 3rd rising edge after the input is first sampled high.
  - Exactly 1 pulse per press, regardless of hold length.
REQ-019 FSM SHALL have states MODE_NORMAL, MODE_SET_HOUR, MODE_SET_MIN.
  - Each mode-button edge advances NORMAL->SET_HOUR->SET_MIN->NORMAL.
REQ-020 In NORMAL, enables SHALL be:
  - sec_en = tick.
  - min_en = tick & sec_carry.
  - hour_en = tick & sec_carry & min_carry.
REQ-021 In SET_HOUR and SET_MIN, sec_en, min_en and hour_en SHALL be 0.
  - Time stops while setting.
REQ-022 A set-button edge SHALL pulse hour_inc in SET_HOUR and min_inc in SET_MIN.
  - Ignored in NORMAL.
REQ-023 On the SET_MIN->NORMAL transition, sec_clr SHALL pulse 1 cycle and the prescaler SHALL restart at 0.
  - First sec_en follows exactly TICK_DIV cycles later.
REQ-024 Mode-edge and set-edge in the same cycle: mode transition SHALL win; no inc pulse issued.
REQ-025 blink SHALL be 1 in NORMAL.
  - In set modes, blink = 1 while prescaler < TICK_DIV/2, else 0.
REQ-026 At most one of hour_inc, min_inc, sec_clr SHALL be high in any cycle.

Reset
REQ-027 While rst=1, the following SHALL hold:
  - mode = MODE_NORMAL; prescaler = 0; synchronizer/edge flops = 0.
  - sec_en, min_en, hour_en, min_inc, hour_inc, sec_clr = 0; blink = 1.
REQ-028 First tick SHALL occur TICK_DIV cycles after rst deasserts.
REQ-029 Reset in any state mid-operation SHALL discard pending button edges.

Structure
REQ-030 Package clock_pkg SHALL hold:
  - mode_t enum (NORMAL=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2).
  - TICK_DIV default constant.
REQ-031 Sub-module btn_edge (sync + edge detect) SHALL be instantiated twice.

Verification (TICK_DIV=10)
REQ-032 rst 3 cycles, then idle -> sec_en pulses every 10 cycles, first on 10th cycle after release; mode=0.
REQ-033 sec_carry=1, min_carry=1 held -> min_en and hour_en coincide with every sec_en pulse; with min_carry=0, hour_en stays 0.
REQ-034 btn_mode held 4 cycles -> mode 0->1 once; 5 btn_set presses -> exactly 5 hour_inc pulses, min_inc=0, sec_en=0.
REQ-035 Two more btn_mode presses -> mode 2 then 0; sec_clr single pulse on 2->0; next sec_en exactly 10 cycles later.
REQ-036 btn_mode and btn_set rising same cycle in mode 1 -> mode=2, no hour_inc/min_inc pulse.
REQ-037 rst asserted in SET_MIN during a btn_set press -> mode=0, no min_inc, prescaler restarts from 0.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the clock controller.
//   mode_t           - controller mode, also driven out on clock_ctrl.mode
//   TICK_DIV_DEFAULT - clk cycles per 1-s tick at 100 MHz
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_t;

    localparam int TICK_DIV_DEFAULT = 100_000_000;

endpackage

// File: rtl/clock_ctrl_btn_edge.sv
// btn_edge: two-flop synchronizer followed by a registered rising-edge
// detector for an asynchronous push button.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   btn_i   in  raw asynchronous button level
//   pulse_o out one-cycle pulse per press, asserted on the 3rd rising
//               edge after the button is first sampled high
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: 1-s prescaler, button handling and mode FSM for a
// HH:MM:SS clock built from external cascaded counters.
//   clk, rst                   system clock, synchronous active-high reset
//   btn_mode, btn_set          asynchronous push buttons
//   sec_carry, min_carry       levels from the seconds/minutes counters (=59)
//   sec_en, min_en, hour_en    count enables (1-cycle pulses)
//   min_inc, hour_inc, sec_clr manual set pulses
//   mode                       current mode_t
//   blink                      display blink gate for the field being set
//
// state         | meaning
// MODE_NORMAL   | time runs, set button ignored
// MODE_SET_HOUR | time frozen, set button increments hours
// MODE_SET_MIN  | time frozen, set button increments minutes;
//               | leaving clears seconds and restarts the prescaler
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_en,
    output logic       min_en,
    output logic       hour_en,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int CW = $clog2(TICK_DIV);

    logic          mode_edge;
    logic          set_edge;
    logic          tick;
    mode_t         mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sec_en_q, sec_en_d;
    logic          min_en_q, min_en_d;
    logic          hour_en_q, hour_en_d;
    logic          min_inc_q, min_inc_d;
    logic          hour_inc_q, hour_inc_d;
    logic          sec_clr_q, sec_clr_d;
    logic          blink_q, blink_d;

    btn_edge u_btn_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_mode),
        .pulse_o (mode_edge)
    );

    btn_edge u_btn_set (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_set),
        .pulse_o (set_edge)
    );

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        mode_d     = mode_q;
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        sec_en_d   = 1'b0;
        min_en_d   = 1'b0;
        hour_en_d  = 1'b0;
        min_inc_d  = 1'b0;
        hour_inc_d = 1'b0;
        sec_clr_d  = 1'b0;
        case (mode_q)
            MODE_NORMAL: begin
                sec_en_d  = tick;
                min_en_d  = tick & sec_carry;
                hour_en_d = tick & sec_carry & min_carry;
                if (mode_edge) mode_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
                // A mode edge wins over a coincident set edge.
                if (mode_edge)     mode_d     = MODE_SET_MIN;
                else if (set_edge) hour_inc_d = 1'b1;
            end
            MODE_SET_MIN: begin
                if (mode_edge) begin
                    mode_d    = MODE_NORMAL;
                    sec_clr_d = 1'b1;
                    cnt_d     = '0;
                end else if (set_edge) begin
                    min_inc_d = 1'b1;
                end
            end
            default: mode_d = MODE_NORMAL;
        endcase
        // Registered from next-state values so blink tracks the flopped
        // mode/prescaler in the same cycle.
        blink_d = (mode_d == MODE_NORMAL) | (cnt_d < CW'(TICK_DIV / 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_NORMAL;
            cnt_q      <= '0;
            sec_en_q   <= 1'b0;
            min_en_q   <= 1'b0;
            hour_en_q  <= 1'b0;
            min_inc_q  <= 1'b0;
            hour_inc_q <= 1'b0;
            sec_clr_q  <= 1'b0;
            blink_q    <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            sec_en_q   <= sec_en_d;
            min_en_q   <= min_en_d;
            hour_en_q  <= hour_en_d;
            min_inc_q  <= min_inc_d;
            hour_inc_q <= hour_inc_d;
            sec_clr_q  <= sec_clr_d;
            blink_q    <= blink_d;
        end
    end

    assign sec_en   = sec_en_q;
    assign min_en   = min_en_q;
    assign hour_en  = hour_en_q;
    assign min_inc  = min_inc_q;
    assign hour_inc = hour_inc_q;
    assign sec_clr  = sec_clr_q;
    assign mode     = mode_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
module tb_clock_ctrl;

    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_set = 1'b0;
    logic       sec_carry = 1'b0;
    logic       min_carry = 1'b0;
    logic       sec_en, min_en, hour_en, min_inc, hour_inc, sec_clr, blink;
    logic [1:0] mode;

    clock_ctrl #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_set   (btn_set),
        .sec_carry (sec_carry),
        .min_carry (min_carry),
        .sec_en    (sec_en),
        .min_en    (min_en),
        .hour_en   (hour_en),
        .min_inc   (min_inc),
        .hour_inc  (hour_inc),
        .sec_clr   (sec_clr),
        .mode      (mode),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: the mode is a counter mod 3, the prescaler a
    // phase mod TD, and a button press is seen by the controller when the
    // sample taken 3 edges ago is high and the one 4 edges ago is low.
    bit model_valid = 0;
    int m_mode = 0;
    int m_phase = 0;
    bit hm [4];
    bit hs [4];
    bit e_sec = 0, e_min = 0, e_hour = 0, e_mi = 0, e_hi = 0, e_clr = 0, e_blink = 1;

    always @(posedge clk) begin
        bit me, se, tk;
        if (rst) begin
            model_valid = 1;
            m_mode = 0;
            m_phase = 0;
            for (int i = 0; i < 4; i++) begin hm[i] = 0; hs[i] = 0; end
            {e_sec, e_min, e_hour, e_mi, e_hi, e_clr} = '0;
            e_blink = 1;
        end else if (model_valid) begin
            me = hm[2] & ~hm[3];
            se = hs[2] & ~hs[3];
            tk = (m_phase == TD - 1);
            e_sec  = (m_mode == 0) && tk;
            e_min  = e_sec && sec_carry;
            e_hour = e_min && min_carry;
            e_hi   = se && !me && (m_mode == 1);
            e_mi   = se && !me && (m_mode == 2);
            e_clr  = me && (m_mode == 2);
            if (me) m_mode = (m_mode + 1) % 3;
            m_phase = e_clr ? 0 : (m_phase + 1) % TD;
            e_blink = (m_mode == 0) || (m_phase < TD / 2);
            for (int i = 3; i > 0; i--) begin hm[i] = hm[i-1]; hs[i] = hs[i-1]; end
            hm[0] = btn_mode;
            hs[0] = btn_set;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("sec_en",   int'(sec_en),   int'(e_sec));
            chk("min_en",   int'(min_en),   int'(e_min));
            chk("hour_en",  int'(hour_en),  int'(e_hour));
            chk("min_inc",  int'(min_inc),  int'(e_mi));
            chk("hour_inc", int'(hour_inc), int'(e_hi));
            chk("sec_clr",  int'(sec_clr),  int'(e_clr));
            chk("mode",     int'(mode),     m_mode);
            chk("blink",    int'(blink),    int'(e_blink));
            chk("onehot_inc_clr", int'(min_inc) + int'(hour_inc) + int'(sec_clr) <= 1, 1);
        end
    end

    int c_sec, c_min, c_hour, c_mi, c_hi, c_clr;

    task automatic clr_counts();
        {c_sec, c_min, c_hour, c_mi, c_hi, c_clr} = '0;
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c_sec  += int'(sec_en);
            c_min  += int'(min_en);
            c_hour += int'(hour_en);
            c_mi   += int'(min_inc);
            c_hi   += int'(hour_inc);
            c_clr  += int'(sec_clr);
        end
    endtask

    task automatic press(input bit is_mode, input int hold, input int gap);
        if (is_mode) btn_mode = 1'b1; else btn_set = 1'b1;
        step(hold);
        if (is_mode) btn_mode = 1'b0; else btn_set = 1'b0;
        step(gap);
    endtask

    // Cycles (negedges) until sec_en is seen; -1 if not within 3*TD.
    task automatic wait_sec(output int k);
        k = -1;
        for (int i = 1; i <= 3 * TD; i++) begin
            step();
            if (sec_en) begin k = i; break; end
        end
    endtask

    initial begin
        int k;
        // Reset 3 cycles, then release and time the first second.
        step(3);
        rst = 1'b0;
        clr_counts();
        wait_sec(k);
        chk("first_sec_after_rst", k, TD);
        chk("mode_after_rst", int'(mode), 0);

        // Carries held: min/hour enables ride on every seconds enable.
        sec_carry = 1'b1;
        min_carry = 1'b1;
        clr_counts();
        step(3 * TD);
        chk("sec_cnt_carry", c_sec, 3);
        chk("hour_cnt_carry", c_hour, 3);
        min_carry = 1'b0;
        clr_counts();
        step(2 * TD);
        chk("min_cnt_nomin", c_min, 2);
        chk("hour_cnt_nomin", c_hour, 0);

        // Enter SET_HOUR with a 4-cycle hold, then 5 set presses.
        sec_carry = 1'b0;
        press(1'b1, 4, 6);
        chk("mode_set_hour", int'(mode), 1);
        clr_counts();
        for (int i = 0; i < 5; i++) press(1'b0, $urandom_range(1, 6), $urandom_range(3, 6));
        step(6);
        chk("hour_inc_count", c_hi, 5);
        chk("min_inc_in_hour", c_mi, 0);
        chk("sec_en_frozen", c_sec, 0);

        // SET_MIN, two set presses, then back to NORMAL.
        press(1'b1, 2, 6);
        chk("mode_set_min", int'(mode), 2);
        clr_counts();
        press(1'b0, 3, 4);
        press(1'b0, 1, 6);
        chk("min_inc_count", c_mi, 2);
        chk("hour_inc_in_min", c_hi, 0);
        clr_counts();
        btn_mode = 1'b1;
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (sec_clr) begin k = i; break; end
        end
        chk("sec_clr_seen", k > 0, 1);
        btn_mode = 1'b0;
        wait_sec(k);
        chk("sec_after_clr", k, TD);
        step(3);
        chk("sec_clr_once", c_clr, 1);
        chk("mode_normal_again", int'(mode), 0);

        // Coincident mode and set press in SET_HOUR: mode wins.
        press(1'b1, 2, 6);
        chk("mode_set_hour2", int'(mode), 1);
        clr_counts();
        btn_mode = 1'b1;
        btn_set  = 1'b1;
        step(3);
        btn_mode = 1'b0;
        btn_set  = 1'b0;
        step(6);
        chk("coinc_mode", int'(mode), 2);
        chk("coinc_inc", c_hi + c_mi, 0);

        // Reset during a set press in SET_MIN.
        clr_counts();
        btn_set = 1'b1;
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        btn_set = 1'b0;
        wait_sec(k);
        chk("rst_mid_mode", int'(mode), 0);
        chk("rst_mid_min_inc", c_mi, 0);
        chk("rst_mid_first_sec", k, TD);

        // Randomised traffic, model-checked every cycle.
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 5) == 0) btn_set  = ~btn_set;
            sec_carry = ($urandom_range(0, 2) == 0);
            min_carry = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
